// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit seven-segment display: one nibble per slot into a shared
// decoder, active-low anodes with an anode-off guard, frame-aligned bank select and edit blinking.
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD_CYC    = 4,
  parameter int BLINK_FRAMES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] time_digits,
  input  logic [15:0] alarm_digits,
  input  logic        alarm_sel,
  input  logic        set_mode,
  input  logic        set_field,
  output logic [3:0]  digit_out,
  output logic [3:0]  an,
  output logic        dp_out,
  output logic        src_is_alarm,
  output logic        frame_done
);

  localparam int PW    = $clog2(SCAN_DIV);
  localparam int GW    = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int GLAST = (GUARD_CYC > 0) ? GUARD_CYC - 1 : 0;
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int BLAST = BLINK_FRAMES - 1;

  typedef enum logic {GUARD = 1'b0, DRIVE = 1'b1} state_t;

  state_t          state, stateNext;
  logic [PW-1:0]   prescale;
  logic [1:0]      idx, idxNext;
  logic [GW-1:0]   guardCnt, guardCntNext;
  logic [BW-1:0]   blinkCnt, blinkCntNext;
  logic            blinkPhase, blinkPhaseNext;
  logic            srcNext;
  logic            tick, frameEnd;
  logic [15:0]     bank;
  logic            blank;
  logic [3:0]      digitNext, anNext;
  logic            dpNext;

  assign tick     = (prescale == PW'(SCAN_DIV - 1));
  assign frameEnd = tick && (idx == 2'd3);

  // State register: all outputs are registered so the anodes never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale     <= '0;
      idx          <= '0;
      guardCnt     <= '0;
      state        <= GUARD;
      blinkCnt     <= '0;
      blinkPhase   <= 1'b0;
      src_is_alarm <= 1'b0;
      frame_done   <= 1'b0;
      an           <= 4'b1111;
      digit_out    <= 4'h0;
      dp_out       <= 1'b1;
    end else begin
      prescale     <= tick ? '0 : prescale + PW'(1);
      idx          <= idxNext;
      guardCnt     <= guardCntNext;
      state        <= stateNext;
      blinkCnt     <= blinkCntNext;
      blinkPhase   <= blinkPhaseNext;
      src_is_alarm <= srcNext;
      frame_done   <= frameEnd;
      an           <= anNext;
      digit_out    <= digitNext;
      dp_out       <= dpNext;
    end
  end

  // Next-state: slot sequencing, guard timing, frame-aligned bank and blink state.
  always_comb begin
    idxNext        = tick ? idx + 2'd1 : idx;
    srcNext        = frameEnd ? alarm_sel : src_is_alarm;
    stateNext      = state;
    guardCntNext   = guardCnt;
    blinkCntNext   = blinkCnt;
    blinkPhaseNext = blinkPhase;

    if (tick) begin
      guardCntNext = '0;
      stateNext    = (GUARD_CYC == 0) ? DRIVE : GUARD;
    end else if (state == GUARD) begin
      if (GUARD_CYC == 0 || guardCnt == GW'(GLAST))
        stateNext = DRIVE;
      else
        guardCntNext = guardCnt + GW'(1);
    end

    if (!set_mode) begin
      blinkCntNext   = '0;
      blinkPhaseNext = 1'b0;
    end else if (frameEnd) begin
      if (blinkCnt == BW'(BLAST)) begin
        blinkCntNext   = '0;
        blinkPhaseNext = ~blinkPhase;
      end else begin
        blinkCntNext = blinkCnt + BW'(1);
      end
    end
  end

  // Outputs are computed from next-state values so they line up with the slot they belong to.
  always_comb begin
    bank      = srcNext ? alarm_digits : time_digits;
    digitNext = bank[{idxNext, 2'b00} +: 4];
    blank     = set_mode && blinkPhaseNext && (idxNext[1] == set_field);
    anNext    = 4'b1111;
    if (stateNext == DRIVE && !blank)
      anNext[idxNext] = 1'b0;
    dpNext    = !(stateNext == DRIVE && idxNext == 2'd2 && srcNext);
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit seven-segment display.
- Sequences a single shared BCD-to-segment decoder across the four digits by selecting one nibble per digit slot and driving the matching anode.
- Chooses between the time bank and the alarm bank, switching only on frame boundaries.
- Inserts anode-off guard time to suppress ghosting, and blinks the field being edited in set mode.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 kHz digit rate at 100 MHz); must be >= 2.
- GUARD_CYC, 4: anode-off cycles at the start of each slot; 0 <= GUARD_CYC < SCAN_DIV.
- BLINK_FRAMES, 128: frames per blink half-period; must be >= 1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- time_digits  in  16  time bank, nibble k = digit k (digit 0 = minutes units, digit 3 = hours tens).
- alarm_digits  in  16  alarm bank, same layout as time_digits.
- alarm_sel  in  1  1 = show alarm bank; sampled only at frame boundary.
- set_mode  in  1  1 = editing; enables blinking.
- set_field  in  1  0 = minutes (digits 0,1) blink; 1 = hours (digits 2,3) blink.
- digit_out  out  4  nibble for the shared segment decoder.
- an  out  4  anodes, active-low, at most one low.
- dp_out  out  1  decimal point, active-low.
- src_is_alarm  out  1  latched bank select currently displayed.
- frame_done  out  1  one-cycle pulse on each 3->0 digit wrap.

Behaviour:
- Reset (async, immediate) sets every register as follows:
  - prescaler = 0, idx = 0, guard counter = 0, state = GUARD
  - an = 4'b1111, digit_out = 0, dp_out = 1
  - src_is_alarm = 0, frame_done = 0
  - blink frame counter = 0, blink_phase = 0
- After reset is released, the first slot is idx 0 with digit_out = time_digits[3:0].
- Prescaler:
  - Counts 0..SCAN_DIV-1 continuously and wraps to 0.
  - tick = (prescaler == SCAN_DIV-1).
- On the edge where tick = 1:
  - idx <= idx+1 mod 4.
  - digit_out <= nibble idx_next of the bank chosen by the src_is_alarm value in effect for the new slot.
  - an <= 1111.
  - Guard counter cleared; state <= GUARD. If GUARD_CYC = 0, state goes straight to DRIVE and the anode is asserted on the same edge.
- State machine, GUARD -> DRIVE:
  - GUARD holds an = 1111 for exactly GUARD_CYC cycles, then moves to DRIVE.
  - DRIVE sets an[idx] = 0 unless the slot is blanked, and holds until the next tick.
- Frame boundary (tick with idx == 3):
  - frame_done = 1 for exactly the following cycle.
  - src_is_alarm <= alarm_sel, so the new frame's digit 0 already uses the new bank.
  - A toggle of alarm_sel mid-frame has no effect until the boundary.
- Live data: digit_out is re-sampled from the selected bank every cycle while in the slot, so digit updates appear without waiting for the next slot. Nibbles > 9 pass through unmodified.
- Blink:
  - The blink frame counter increments on each frame boundary while set_mode = 1.
  - At BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
  - When set_mode = 0, the counter and blink_phase are held at 0 synchronously, so blinking stops within 1 cycle.
  - When set_mode = 1 and blink_phase = 1, slots in the selected field keep an = 1111 during DRIVE.
  - A set_field change takes effect at the next DRIVE.
- dp_out = 0 only during DRIVE of idx 2 with src_is_alarm = 1 (alarm indicator); 1 otherwise, including during GUARD.
- Simultaneous events: a frame boundary and a blink toggle on the same tick are both applied; the new frame uses the new blink_phase.

Test Plan:
Bench parameters for all scenarios: SCAN_DIV = 8, GUARD_CYC = 2, BLINK_FRAMES = 2; cycle 0 is the first edge after reset is released.
- Reset/scan, time_digits = 16'h1234:
  - an = 1111 during cycles 0-1; an = 1110 with digit_out = 4 during cycles 2-7.
  - At edge 8: an = 1111, digit_out = 3; an = 1101 from cycle 10.
  - Digit order 4, 3, 2, 1 repeats; frame_done pulses every 32 cycles.
- Bank switch, alarm_digits = 16'h0630, alarm_sel raised mid-frame at idx 1:
  - Remainder of the frame still shows the time bank.
  - Next frame shows 0, 3, 6, 0; src_is_alarm rises on the boundary edge; dp_out = 0 only in idx 2 DRIVE.
- Blink, set_mode = 1, set_field = 1:
  - Frames 0-1 all four anodes pulse.
  - Frames 2-3 an[2] and an[3] stay high while digits 0-1 still pulse; this alternates.
  - Dropping set_mode restores all anodes within 1 cycle.
- GUARD_CYC = 0 variant: anode asserted on the tick edge itself; no cycle with an = 1111 between slots.
- Async reset asserted mid-DRIVE of idx 2:
  - an = 1111, dp_out = 1, src_is_alarm = 0 immediately, without waiting for a clock edge.
  - Scan restarts at idx 0 after release.
